// File: rtl/freq_gate_ctrl_if.sv
// freq_gate_ctrl_if: control/status bundle between the gate-window controller and the BCD digit chain
//   master (controller): in  oneHz, sig_in, run, top_carry; out add, clr, latch, ovf, gating
//   slave  (datapath/stimulus): the mirror image
interface freq_gate_ctrl_if;
    logic oneHz;
    logic sig_in;
    logic run;
    logic top_carry;
    logic add;
    logic clr;
    logic latch;
    logic ovf;
    logic gating;
    modport master (input oneHz, sig_in, run, top_carry, output add, clr, latch, ovf, gating);
    modport slave (output oneHz, sig_in, run, top_carry, input add, clr, latch, ovf, gating);
endinterface

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate-window controller for the BCD frequency counter
//   gclk  : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : freq_gate_ctrl_if.master (oneHz tick, sig_in, run, top_carry in;
//           add pulse, clr, latch, ovf, gating out)
module freq_gate_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int WINDOW_SEC  = 1
) (
    input logic             gclk,
    input logic             reset,
    freq_gate_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, ARM, CLEAR, GATE, LATCH} state_t;
    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   sig_edge;
    logic                   closing;
    logic                   acc;
    logic                   add_q;
    logic                   ovf_q;
    logic [3:0]             ticks;
    assign sig_edge = sync[SYNC_STAGES-1] & ~prev;
    assign closing  = (state == GATE) && (state_nx == LATCH);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.run ? ARM : IDLE;
            ARM:     state_nx = !bus.run ? IDLE : bus.oneHz ? CLEAR : ARM;
            CLEAR:   state_nx = bus.run ? GATE : IDLE;
            GATE:    state_nx = !bus.run ? IDLE :
                                (bus.oneHz && ticks == 4'(WINDOW_SEC - 1)) ? LATCH : GATE;
            LATCH:   state_nx = CLEAR;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge gclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sync  <= '0;
            prev  <= 1'b0;
            ticks <= 4'd0;
            acc   <= 1'b0;
            add_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nx;
            sync  <= {sync[SYNC_STAGES-2:0], bus.sig_in};
            prev  <= sync[SYNC_STAGES-1];
            // an edge on the closing-tick cycle belongs to no window: half-open gate
            add_q <= sig_edge && (state == GATE) && (state_nx == GATE);
            if (state == CLEAR)
                ticks <= 4'd0;
            else if (state == GATE && bus.oneHz)
                ticks <= ticks + 4'd1;
            if (state == CLEAR)
                acc <= 1'b0;
            else if (add_q && bus.top_carry)
                acc <= 1'b1;
            // the add still in flight on the closing cycle can carry too
            if (closing)
                ovf_q <= acc | (add_q & bus.top_carry);
        end
    end
    assign bus.add    = add_q;
    assign bus.clr    = (state == CLEAR);
    assign bus.latch  = (state == LATCH);
    assign bus.gating = (state == GATE);
    assign bus.ovf    = ovf_q;
endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Gate-window controller for the BCD frequency-counter datapath. It synchronizes an asynchronous input signal and converts each rising edge into a one-cycle `add` pulse for the digit chain. Gate windows are timed from the `oneHz` tick. The block clears the chain before each window, latches the result for display at window close, and flags overflow from the most-significant digit's carry.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `sig_in`, legal range 2 to 4.
- `WINDOW_SEC`, default 1: gate window length in `oneHz` ticks, legal range 1 to 15.

- `gclk`  input  1  system clock; all flops clock on its rising edge.
- `reset`  input  1  asynchronous active-low reset.
- `oneHz`  input  1  one-`gclk`-cycle tick, once per second.
- `sig_in`  input  1  asynchronous signal to measure.
- `run`  input  1  level; 1 = measure continuously, 0 = stop.
- `top_carry`  input  1  combinational carry out of the most-significant BCD digit.
- `add`  output  1  registered increment pulse to the least-significant digit.
- `clr`  output  1  synchronous clear to all digits; high for 1 cycle.
- `latch`  output  1  display-register load strobe; high for 1 cycle.
- `ovf`  output  1  overflow flag for the most recently latched window.
- `gating`  output  1  high while the window is open (state GATE).

## Operation
- Synchronizer and edge detection:
  - `sig_in` passes through `SYNC_STAGES` flops, then a `prev` flop.
  - Edge = last sync stage & ~`prev`.
  - All of these flops reset to 0.
- FSM states: IDLE, ARM, CLEAR, GATE, LATCH. Reset state is IDLE.
  - IDLE: go to ARM when `run`=1.
  - ARM:
    - `run`=0 → IDLE.
    - `oneHz`=1 → CLEAR.
    - Otherwise wait. This aligns the first window to a tick.
  - CLEAR (`clr`=1):
    - Reset the tick counter and the overflow accumulator.
    - Then go to GATE if `run`=1, else IDLE.
  - GATE (`gating`=1):
    - `run`=0 → IDLE immediately. No latch; the accumulator is discarded.
    - Each `oneHz` increments the tick counter (4-bit).
    - When `oneHz` arrives with tick count == `WINDOW_SEC`-1 → LATCH. This is the closing tick.
  - LATCH (`latch`=1): next state CLEAR, giving back-to-back windows. The `run` check happens in CLEAR.
- `add` register: next value = edge & (next state == GATE) & (state == GATE).
  - An edge detected on the closing-tick cycle, or outside GATE, is dropped.
  - The window is half-open.
- Overflow:
  - The accumulator sets whenever `add`=1 and `top_carry`=1.
  - On the closing-tick edge, `ovf` ← accumulator | (`add` & `top_carry`).
  - `ovf` holds until the next window closes or reset.
- `oneHz` is ignored in IDLE, CLEAR and LATCH.
- `clr`, `latch` and `gating` are decoded from the state register, so they are glitch-free registered values.

## Timing
- Reset values: state IDLE; `add`=0, `clr`=0, `latch`=0, `ovf`=0, `gating`=0. Tick counter, accumulator and sync flops are all 0.
- Reset asserted mid-window: immediate return to IDLE with all outputs 0. The digit chain is not cleared by this block.
- Start-up sequence:
  - `run`=1 at edge E.
  - ARM at E+1.
  - `oneHz` sampled at edge T → `clr` high during cycle T+1 → `gating` high from T+2.
- `add` latency: with `sig_in` high before edge E0, `add` is high during the cycle following edge E(`SYNC_STAGES`).
- `sig_in` must stay high ≥2 and low ≥2 `gclk` periods to be counted reliably.
- An `add` high on the closing-tick cycle is still counted. The digit chain updates at the end of that cycle, so `latch` (next cycle) sees the final value.
- Window close:
  - Closing tick at edge C → `latch` high in cycle C+1 → `clr` in C+2 → `gating` again from C+3.
  - Dead time between windows is 2 cycles.
- Window length: `WINDOW_SEC` seconds minus 2 cycles.
- Minimum `gclk` is 4 cycles per `sig_in` period. Faster inputs are undercounted.

## Test plan
- Reset and arming: assert/release `reset`; all outputs 0. With `run`=1 and no `oneHz` for 1000 cycles, state stays ARM and `clr`=`add`=0.
- Basic window (`WINDOW_SEC`=1): tick at T, then 37 `sig_in` pulses (4 high / 4 low), then tick at C.
  - `clr` in T+1.
  - Exactly 37 `add` pulses.
  - `latch` in C+1.
  - `ovf`=0.
- Closing-edge boundary:
  - Edge detected on the cycle before C → counted (`add` in cycle C).
  - Edge detected at C → no `add`.
- Overflow: hold `top_carry`=1 during one `add` → `ovf`=1 with `latch`. The following window has no carry → `ovf`=0 at its latch.
- Abort: drop `run` mid-GATE → IDLE next cycle, no further `add`, no `latch`. Re-assert `run` → waits for the next `oneHz`.
- `WINDOW_SEC`=3: `latch` only after the third tick in GATE. A `oneHz` during CLEAR does not advance the tick count.
